// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router constants: port codes, scheduler FSM encoding, defaults
package noc_pkg;

    localparam int DSIZE_DEF   = 32;
    localparam int CREDITS_DEF = 32;

    localparam logic [2:0] PORT_N       = 3'd0;
    localparam logic [2:0] PORT_S       = 3'd1;
    localparam logic [2:0] PORT_E       = 3'd2;
    localparam logic [2:0] PORT_W       = 3'd3;
    localparam logic [2:0] PORT_L       = 3'd4;
    localparam logic [2:0] PORT_INVALID = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_SEND  = 2'd3;

endpackage

// File: rtl/rr_pointer_arbiter.sv
// rtl/rr_pointer_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_pointer_arbiter #(
    parameter int NREQ = 5
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      pointer,
    output logic            valid,
    output logic [2:0]      idx
);

    int         pos;
    logic [2:0] pos3;

    // Walk pointer, pointer+1, ... wrapping; the first set bit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        pos3  = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(pointer) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            pos3 = 3'(pos);
            if (!valid && req[pos3]) begin
                valid = 1'b1;
                idx   = pos3;
            end
        end
    end

endmodule

// File: rtl/output_scheduler.sv
// rtl/output_scheduler.sv - per-direction output link scheduler with round-robin grant and credits
module output_scheduler
    import noc_pkg::*;
#(
    parameter int DSIZE   = DSIZE_DEF,
    parameter int NREQ    = 5,
    parameter int CREDITS = CREDITS_DEF,
    parameter int CW      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] data_in,
    output logic [NREQ-1:0]       read_en,
    input  logic                  credit_in,
    output logic [DSIZE-1:0]      data_out,
    output logic                  valid_out,
    output logic [2:0]            grant_idx,
    output logic [CW-1:0]         credits,
    output logic                  credit_err
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic [1:0]       state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       grant_q, grant_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             err_q, err_d;
    logic [DSIZE-1:0] data_q, data_d;

    logic             arb_valid;
    logic [2:0]       arb_idx;
    logic             grant_fire;
    logic [DSIZE-1:0] sel_word;

    rr_pointer_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .pointer (ptr_q),
        .valid   (arb_valid),
        .idx     (arb_idx)
    );

    assign grant_fire = (state_q == ST_IDLE) && arb_valid && (credits_q != '0);

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == 3'(i)) begin
                sel_word = data_in[i*DSIZE +: DSIZE];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        credits_d = credits_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_fire) begin
                    grant_d = arb_idx;
                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: begin
                data_d  = sel_word;
                ptr_d   = (grant_q == 3'(NREQ - 1)) ? 3'd0 : grant_q + 3'd1;
                state_d = ST_SEND;
            end
            ST_SEND:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // A grant reserves a downstream slot; a returning credit frees one.
        case ({grant_fire, credit_in})
            2'b10: credits_d = credits_q - 1'b1;
            2'b01: begin
                if (credits_q == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + 1'b1;
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= PORT_N;
            grant_q   <= PORT_N;
            data_q    <= '0;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign read_en    = (state_q == ST_READ) ? (NREQ'(1) << grant_q) : '0;
    assign valid_out  = (state_q == ST_SEND);
    assign data_out   = data_q;
    assign grant_idx  = grant_q;
    assign credits    = credits_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_output_scheduler.sv
// tb/tb_output_scheduler.sv - directed self-checking bench for output_scheduler
module tb_output_scheduler;

    logic         clk;
    logic         reset;
    logic [4:0]   req;
    logic [159:0] data_in;
    logic [4:0]   read_en;
    logic         credit_in;
    logic [31:0]  data_out;
    logic         valid_out;
    logic [2:0]   grant_idx;
    logic [5:0]   credits;
    logic         credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    output_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data_in    (data_in),
        .read_en    (read_en),
        .credit_in  (credit_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .grant_idx  (grant_idx),
        .credits    (credits),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        int         g;
        bit         drop;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data(input logic [31:0] base);
        for (int i = 0; i < 5; i++) begin
            data_in[i*32 +: 32] = base + 32'(i);
        end
    endtask

    // Called in an IDLE cycle; returns in the following IDLE cycle.
    task automatic run_packet(input logic [4:0] r, input int g, input logic [31:0] base,
                              input int cred, input bit drop);
        logic [4:0] oh;
        oh = 5'b00001 << g;
        req = r;
        load_data(base);
        tick();
        check("read_en", 64'(read_en), 64'(oh));
        check("grant_idx", 64'(grant_idx), 64'(g));
        if (drop) req = 5'b0;
        tick();
        check("read_en_single", 64'(read_en), 64'd0);
        check("valid_early", 64'(valid_out), 64'd0);
        tick();
        check("valid_send", 64'(valid_out), 64'd1);
        check("data_out", 64'(data_out), 64'(base + 32'(g)));
        check("credits", 64'(credits), 64'(cred));
        tick();
        check("valid_one_cycle", 64'(valid_out), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 10; k++) vecs[k] = '{5'b11111, k % 5, 1'b0};
        vecs[10] = '{5'b00001, 0, 1'b0};
        vecs[11] = '{5'b00001, 0, 1'b0};
        vecs[12] = '{5'b10100, 2, 1'b0};
        vecs[13] = '{5'b00101, 0, 1'b0};
        vecs[14] = '{5'b10000, 4, 1'b0};
        vecs[15] = '{5'b01010, 1, 1'b1};

        reset     = 1'b0;
        req       = 5'b0;
        data_in   = '0;
        credit_in = 1'b0;
        tick();
        tick();
        check("rst_read_en", 64'(read_en), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_grant", 64'(grant_idx), 64'd0);
        check("rst_credits", 64'(credits), 64'd32);
        check("rst_err", 64'(credit_err), 64'd0);
        reset = 1'b1;

        for (int k = 0; k < 16; k++) begin
            run_packet(vecs[k].req, vecs[k].g, 32'hA5A5_0001 + (32'(k) << 8), 31 - k, vecs[k].drop);
        end

        for (int j = 0; j < 16; j++) begin
            run_packet(5'b00100, 2, 32'h5A5A_0000 + (32'(j) << 8), 15 - j, 1'b0);
        end
        req = 5'b00100;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("starved_read_en", 64'(read_en), 64'd0);
            check("starved_credits", 64'(credits), 64'd0);
        end

        credit_in = 1'b1;
        tick();
        check("credit_ret", 64'(credits), 64'd1);
        check("credit_ret_no_read", 64'(read_en), 64'd0);
        credit_in = 1'b0;
        tick();
        check("resume_read_en", 64'(read_en), 64'b00100);
        check("resume_credits", 64'(credits), 64'd0);
        tick();
        tick();
        check("resume_valid", 64'(valid_out), 64'd1);
        req = 5'b0;
        tick();

        credit_in = 1'b1;
        repeat (10) tick();
        credit_in = 1'b0;
        check("refill10", 64'(credits), 64'd10);
        req       = 5'b00001;
        credit_in = 1'b1;
        tick();
        check("same_edge_credits", 64'(credits), 64'd10);
        check("same_edge_read_en", 64'(read_en), 64'b00001);
        credit_in = 1'b0;
        req       = 5'b0;
        repeat (3) tick();

        credit_in = 1'b1;
        repeat (22) tick();
        check("full_credits", 64'(credits), 64'd32);
        check("full_no_err", 64'(credit_err), 64'd0);
        tick();
        check("over_credits", 64'(credits), 64'd32);
        check("over_err", 64'(credit_err), 64'd1);
        credit_in = 1'b0;
        repeat (3) tick();
        check("err_sticky", 64'(credit_err), 64'd1);

        req = 5'b00010;
        tick();
        check("pre_rst_read_en", 64'(read_en), 64'b00010);
        check("pre_rst_grant", 64'(grant_idx), 64'd1);
        tick();
        reset = 1'b0;
        #1;
        check("async_read_en", 64'(read_en), 64'd0);
        check("async_valid", 64'(valid_out), 64'd0);
        check("async_data", 64'(data_out), 64'd0);
        check("async_grant", 64'(grant_idx), 64'd0);
        check("async_credits", 64'(credits), 64'd32);
        check("async_err", 64'(credit_err), 64'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("rst_hold_valid", 64'(valid_out), 64'd0);
        end
        reset = 1'b1;
        run_packet(5'b11111, 0, 32'hC0DE_0000, 31, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_scheduler.md
Name: output_scheduler

Overview:
- Per-output-port scheduler. Shares one router output link between the five input modules whose VC buffer for this direction is non-empty.
- Grants are round-robin. The scheduler issues a single-cycle read to the granted VC buffer and captures the word one cycle later. It then drives the word onto the link for one cycle.
- Credit-based flow control tracks free slots in the downstream VC buffer. One instance sits per output direction (N,S,E,W,L) between the input modules and the link.

Parameters:
- DSIZE, 32, flit/packet width in bits.
- NREQ, 5, requester count; bit order {L,W,E,S,N}.
- CREDITS, 32, downstream VC buffer depth; credit counter reset value.
- CW, 6, credit counter width; must hold CREDITS.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NREQ  bit i = input module i has a non-empty VC buffer for this direction.
- data_in  in  NREQ*DSIZE  word i at bits [i*DSIZE +: DSIZE]; VC buffer output of input module i.
- read_en  out  NREQ  one-hot read pulse to the granted input module.
- credit_in  in  1  one-cycle pulse; downstream freed one slot.
- data_out  out  DSIZE  link data.
- valid_out  out  1  data_out valid; exactly one cycle per packet.
- grant_idx  out  3  index of the current/last grant; debug and monitoring.
- credits  out  CW  current credit count.
- credit_err  out  1  sticky; credit_in arrived while credits == CREDITS.

Behaviour:
Reset values:
- read_en=0, valid_out=0, data_out=0, grant_idx=0, credits=CREDITS, credit_err=0.
- RR pointer=0 (N highest priority), state=IDLE.

FSM states: IDLE, READ, LATCH, SEND.
- IDLE: if (req!=0 && credits!=0), choose the grant g by round-robin starting at pointer.
  - Register g into grant_idx, decrement credits (reservation), go to READ.
  - Otherwise stay in IDLE.
  - req is sampled only in IDLE.
- READ: read_en = one-hot(g) for this cycle only; go to LATCH.
- LATCH: the VC buffer presents data one cycle after read_en.
  - Register data_in[g*DSIZE +: DSIZE] into the output register.
  - Pointer = (g+1) mod NREQ. Go to SEND.
- SEND: valid_out=1 with the latched data_out for this cycle; go to IDLE.
  - data_out holds its value after SEND until the next LATCH.

Round-robin:
- Search order is pointer, pointer+1, …, wrapping mod NREQ; the first set req bit wins.
- A single requester is re-granted on consecutive packets.

Throughput and latency:
- One packet per 4 cycles (IDLE→READ→LATCH→SEND).
- Latency from req visible in IDLE to valid_out is 3 cycles.

Credit update, applied on the same edge as the FSM:
- Grant without credit_in: credits-1.
- credit_in without grant: credits+1, saturating at CREDITS. If credits is already CREDITS, the count is unchanged and credit_err is set.
- Grant and credit_in together: count unchanged.
- credits==0: IDLE holds and no read_en is issued, regardless of req.

Boundary conditions:
- If req drops after grant, read_en is still issued and the captured word is forwarded. Upstream guarantees non-empty at grant time.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight word is dropped and the reservation is restored via the reset value.
- credit_err clears only on reset.

Decomposition:
- Shared package noc_pkg holds:
  - port codes N=0, S=1, E=2, W=3, L=4, INVALID=7;
  - FSM state encoding (2 bits);
  - default DSIZE and CREDITS.
- One sub-module: rr_pointer_arbiter.
  - Combinational; inputs req and pointer; outputs a valid flag and the index.
  - The pointer register stays in output_scheduler.

Test Plan:
- Reset then req=5'b00001, data_in[N]=32'hA5A5_0001:
  - cycle+1 read_en=5'b00001;
  - cycle+3 valid_out=1, data_out=32'hA5A5_0001, credits=31.
- req=5'b11111 held for 10 packets → grant order N,S,E,W,L,N,S,E,W,L; each valid_out is 4 cycles apart.
- 32 grants with no credit_in → credits=0. After that, with req=5'b00100 read_en stays 0. One credit_in pulse → the grant resumes next cycle and credits returns to 0.
- credit_in pulsed on the same edge as a grant with credits=10 → credits stays 10.
- credit_in at credits=32 → credits stays 32 and credit_err=1 until reset.
- reset driven low during LATCH → valid_out never asserts for that packet. All outputs take reset values immediately (asynchronously). After release, the pointer is 0 and credits=32.
